// File: rtl/m_ext_ctrl.sv
// Sequencing controller for the combinational RV32M datapath: accepts one
// operation, holds operands for a settling window, then returns the result.
module m_ext_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_req_valid,
  output logic        op_req_ready,
  input  logic [31:0] ip_rs1,
  input  logic [31:0] ip_rs2,
  input  logic [2:0]  ip_funct_3,
  input  logic [4:0]  ip_rd,
  input  logic        ip_flush,
  output logic [31:0] op_ext_rs1,
  output logic [31:0] op_ext_rs2,
  output logic [2:0]  op_ext_funct_3,
  input  logic [31:0] ip_ext_result,
  output logic        op_resp_valid,
  input  logic        ip_resp_ready,
  output logic [31:0] op_resp_result,
  output logic [4:0]  op_resp_rd,
  output logic        op_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        is_div;
  logic        div0;
  logic        ovf;
  logic [31:0] special_result;

  assign op_req_ready = ~ip_flush & ((state == IDLE) | ((state == DONE) & ip_resp_ready));
  assign accept       = ip_req_valid & op_req_ready;

  // Architecturally defined corner cases bypass the datapath entirely.
  assign is_div = ip_funct_3[2];
  assign div0   = is_div & (ip_rs2 == 32'h0000_0000);
  assign ovf    = is_div & ~ip_funct_3[0] &
                  (ip_rs1 == 32'h8000_0000) & (ip_rs2 == 32'hFFFF_FFFF);

  always_comb begin
    special_result = 32'h0000_0000;
    if (div0)
      special_result = ip_funct_3[1] ? ip_rs1 : 32'hFFFF_FFFF;
    else if (ovf)
      special_result = ip_funct_3[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

  // NOTE: sequential state uses non-blocking assignments only; the operand
  // and result registers are reset too because they drive ports directly.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state          <= IDLE;
      cnt            <= 6'd0;
      result_q       <= 32'h0000_0000;
      rd_q           <= 5'd0;
      op_ext_rs1     <= 32'h0000_0000;
      op_ext_rs2     <= 32'h0000_0000;
      op_ext_funct_3 <= 3'd0;
    end else if (ip_flush) begin
      state <= IDLE;
    end else if (accept) begin
      op_ext_rs1     <= ip_rs1;
      op_ext_rs2     <= ip_rs2;
      op_ext_funct_3 <= ip_funct_3;
      rd_q           <= ip_rd;
      if (div0 | ovf) begin
        result_q <= special_result;
        state    <= DONE;
      end else begin
        cnt   <= is_div ? DIV_CNT : MUL_CNT;
        state <= WAIT;
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
          end else begin
            result_q <= ip_ext_result;
            state    <= DONE;
          end
        end
        DONE: begin
          if (ip_resp_ready)
            state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign op_resp_valid  = (state == DONE);
  assign op_busy        = (state != IDLE);
  assign op_resp_result = result_q;
  assign op_resp_rd     = rd_q;

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Scoreboard bench for m_ext_ctrl with a settling-aware RV32M datapath model.
module tb_m_ext_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 4;

  logic        ip_clk = 1'b0;
  logic        ip_rst;
  logic        ip_req_valid;
  logic        op_req_ready;
  logic [31:0] ip_rs1;
  logic [31:0] ip_rs2;
  logic [2:0]  ip_funct_3;
  logic [4:0]  ip_rd;
  logic        ip_flush;
  logic [31:0] op_ext_rs1;
  logic [31:0] op_ext_rs2;
  logic [2:0]  op_ext_funct_3;
  logic [31:0] ip_ext_result;
  logic        op_resp_valid;
  logic        ip_resp_ready;
  logic [31:0] op_resp_result;
  logic [4:0]  op_resp_rd;
  logic        op_busy;

  m_ext_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .ip_clk         (ip_clk),
    .ip_rst         (ip_rst),
    .ip_req_valid   (ip_req_valid),
    .op_req_ready   (op_req_ready),
    .ip_rs1         (ip_rs1),
    .ip_rs2         (ip_rs2),
    .ip_funct_3     (ip_funct_3),
    .ip_rd          (ip_rd),
    .ip_flush       (ip_flush),
    .op_ext_rs1     (op_ext_rs1),
    .op_ext_rs2     (op_ext_rs2),
    .op_ext_funct_3 (op_ext_funct_3),
    .ip_ext_result  (ip_ext_result),
    .op_resp_valid  (op_resp_valid),
    .ip_resp_ready  (ip_resp_ready),
    .op_resp_result (op_resp_result),
    .op_resp_rd     (op_resp_rd),
    .op_busy        (op_busy)
  );

  always #5 ip_clk = ~ip_clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          acc_cyc     = 0;
  int          pop_edge    = -1;
  bit          lat_checked = 1'b0;
  logic [31:0] ext_rs1_exp = '0;
  logic [31:0] ext_rs2_exp = '0;
  logic [2:0]  ext_f3_exp  = '0;
  int unsigned since       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference RV32M arithmetic; divide corner cases return junk so that
  // any use of the datapath for them shows up as a wrong result.
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] ss;
    logic signed [63:0] su;
    logic        [63:0] uu;
    logic               sovf;
    ss   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    su   = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
    uu   = {32'h0, a} * {32'h0, b};
    sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0:    return uu[31:0];
      3'd1:    return ss[63:32];
      3'd2:    return su[63:32];
      3'd3:    return uu[63:32];
      3'd4:    return (b == 0 || sovf) ? 32'hDEAD_BEEF : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hDEAD_BEEF : a / b;
      3'd6:    return (b == 0 || sovf) ? 32'hDEAD_BEEF : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? 32'hDEAD_BEEF : a % b;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    if (f3[2] && b == 0)
      return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f3[1] ? 32'h0 : 32'h8000_0000;
    return rv32m(f3, a, b);
  endfunction

  function automatic int unsigned exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return f3[2] ? DIV_LAT : MUL_LAT;
  endfunction

  // Datapath model: only shows the true result once operands have been held
  // for the full settling window.
  int unsigned cur_lat;
  assign cur_lat       = op_ext_funct_3[2] ? DIV_LAT : MUL_LAT;
  assign ip_ext_result = (since >= cur_lat - 1) ? rv32m(op_ext_funct_3, op_ext_rs1, op_ext_rs2)
                                                : (32'hBAD0_0000 ^ since);

  always @(posedge ip_clk) begin
    cyc <= cyc + 1;
    if (ip_req_valid && op_req_ready) since <= 0;
    else if (since < 1000) since <= since + 1;
  end

  always @(negedge ip_clk) begin
    if (!ip_rst) begin
      if (op_busy) begin
        check("ext_rs1_stable", op_ext_rs1, ext_rs1_exp);
        check("ext_rs2_stable", op_ext_rs2, ext_rs2_exp);
        check("ext_f3_stable", 32'(op_ext_funct_3), 32'(ext_f3_exp));
      end
      if (op_resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(op_resp_valid), 32'd0);
        end else begin
          if (!lat_checked) begin
            check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
            lat_checked = 1'b1;
          end
          if (ip_resp_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("resp_result", op_resp_result, e.result);
            check("resp_rd", 32'(op_resp_rd), 32'(e.rd));
            lat_checked = 1'b0;
            pop_edge    = cyc + 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int unsigned lat);
    int n;
    exp_t e;
    n            = 0;
    ip_req_valid = 1'b1;
    ip_funct_3   = f3;
    ip_rs1       = a;
    ip_rs2       = b;
    ip_rd        = rd;
    forever begin
      @(negedge ip_clk);
      if (op_req_ready) break;
      n++;
      if (n >= 200) begin
        check("req_ready_timeout", 32'(op_req_ready), 32'd1);
        ip_req_valid = 1'b0;
        return;
      end
    end
    @(posedge ip_clk);
    #1;
    e.result     = exp;
    e.rd         = rd;
    e.lat        = lat;
    sb.push_back(e);
    acc_cyc      = cyc;
    ext_rs1_exp  = a;
    ext_rs2_exp  = b;
    ext_f3_exp   = f3;
    ip_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge ip_clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge ip_clk);
      n++;
    end while (!op_resp_valid && n < 200);
    if (!op_resp_valid) check("valid_timeout", 32'(op_resp_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(op_req_ready), 32'd1);
    check({pfx, "_resp_valid"}, 32'(op_resp_valid), 32'd0);
    check({pfx, "_busy"}, 32'(op_busy), 32'd0);
    check({pfx, "_ext_rs1"}, op_ext_rs1, 32'd0);
    check({pfx, "_ext_rs2"}, op_ext_rs2, 32'd0);
    check({pfx, "_ext_f3"}, 32'(op_ext_funct_3), 32'd0);
    check({pfx, "_result"}, op_resp_result, 32'd0);
    check({pfx, "_rd"}, 32'(op_resp_rd), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int flush_edge;
    ip_rst        = 1'b1;
    ip_req_valid  = 1'b0;
    ip_rs1        = '0;
    ip_rs2        = '0;
    ip_funct_3    = '0;
    ip_rd         = '0;
    ip_flush      = 1'b0;
    ip_resp_ready = 1'b1;
    repeat (2) @(posedge ip_clk);
    @(negedge ip_clk);
    check_reset_outputs("rst");
    @(posedge ip_clk);
    #1 ip_rst = 1'b0;

    // MUL with stable operands through the window
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
    drain();

    // Divide by zero, back-to-back
    issue(3'b100, 32'd100, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
    issue(3'b111, 32'd100, 32'd0, 5'd7, 32'd100, 0);
    drain();

    // Signed overflow and the unsigned case that must take the normal path
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 0);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, DIV_LAT);
    drain();

    // Backpressure in DONE, then both handshakes on one edge
    ip_resp_ready = 1'b0;
    issue(3'b000, 32'h1234_5678, 32'd9, 5'd11, 32'hA3D7_0A38, MUL_LAT);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge ip_clk);
      check("bp_valid", 32'(op_resp_valid), 32'd1);
      check("bp_result", op_resp_result, 32'hA3D7_0A38);
      check("bp_rd", 32'(op_resp_rd), 32'd11);
      check("bp_req_ready", 32'(op_req_ready), 32'd0);
    end
    @(posedge ip_clk);
    #1 ip_resp_ready = 1'b1;
    issue(3'b001, 32'h4000_0000, 32'd4, 5'd12, 32'd1, MUL_LAT);
    check("b2b_same_edge", 32'(acc_cyc), 32'(pop_edge));
    drain();

    // Flush in the second WAIT cycle with a request held during the flush
    issue(3'b100, 32'd1000, 32'd7, 5'd13, 32'd142, DIV_LAT);
    @(posedge ip_clk);
    #1;
    ip_flush     = 1'b1;
    ip_req_valid = 1'b1;
    ip_funct_3   = 3'b000;
    ip_rs1       = 32'd3;
    ip_rs2       = 32'd5;
    ip_rd        = 5'd14;
    @(negedge ip_clk);
    check("flush_req_ready", 32'(op_req_ready), 32'd0);
    @(posedge ip_clk);
    #1;
    ip_flush   = 1'b0;
    flush_edge = cyc;
    void'(sb.pop_front());
    lat_checked = 1'b0;
    check("flush_busy", 32'(op_busy), 32'd0);
    check("flush_valid", 32'(op_resp_valid), 32'd0);
    issue(3'b000, 32'd3, 32'd5, 5'd14, 32'd15, MUL_LAT);
    check("flush_accept_edge", 32'(acc_cyc), 32'(flush_edge + 1));
    drain();

    // Flush while a result is being taken: the handover still completes
    issue(3'b101, 32'd55, 32'd0, 5'd15, 32'hFFFF_FFFF, 0);
    ip_flush = 1'b1;
    @(posedge ip_clk);
    #1 ip_flush = 1'b0;
    check("flush_consumed", 32'(sb.size()), 32'd0);
    check("flush_done_valid", 32'(op_resp_valid), 32'd0);

    // Reset while holding a result in DONE
    ip_resp_ready = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 5'd16, 32'd42, MUL_LAT);
    wait_valid();
    @(posedge ip_clk);
    #1 ip_rst = 1'b1;
    @(posedge ip_clk);
    @(negedge ip_clk);
    check_reset_outputs("mid_rst");
    @(posedge ip_clk);
    #1;
    ip_rst        = 1'b0;
    sb.delete();
    lat_checked   = 1'b0;
    ip_resp_ready = 1'b1;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, MUL_LAT);
    drain();

    // Random mix including the corner-case operands
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      issue(f3, a, b, 5'($urandom_range(0, 31)), exp_result(f3, a, b), exp_lat(f3, a, b));
    end
    drain();

    repeat (3) @(posedge ip_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_ext_ctrl.md
# m_ext_ctrl

Sequencing controller for the combinational RV32M multiply/divide datapath (`m_ext`). It accepts one M-extension operation at a time from the execute stage through a valid/ready handshake and registers the operands into the datapath. It holds them stable for a programmable multicycle settling window, then captures the result and presents it with the destination tag through a second valid/ready handshake. RISC-V divide-by-zero and signed-overflow cases complete in one cycle using architecturally defined results, so the datapath output is never used for them.

## Interface
Parameters:
- MUL_LAT, 2: settling cycles for funct3[2]=0 (MUL/MULH/MULHSU/MULHU); legal 1..63
- DIV_LAT, 4: settling cycles for funct3[2]=1 (DIV/DIVU/REM/REMU); legal 1..63

Ports:
- ip_clk  in  1  clock; all state changes on rising edge
- ip_rst  in  1  reset, synchronous, active-high
- ip_req_valid  in  1  request present
- op_req_ready  out  1  controller can accept a request
- ip_rs1, ip_rs2  in  32  source operands
- ip_funct_3  in  3  M-extension funct3
- ip_rd  in  5  destination tag, returned unchanged
- ip_flush  in  1  pipeline kill; abandons any in-flight operation
- op_ext_rs1, op_ext_rs2  out  32  registered operands to the datapath
- op_ext_funct_3  out  3  registered funct3 to the datapath
- ip_ext_result  in  32  datapath result
- op_resp_valid  out  1  result available
- ip_resp_ready  in  1  consumer accepts result
- op_resp_result  out  32  final result
- op_resp_rd  out  5  destination tag of the result
- op_busy  out  1  state is not IDLE

## Operation
- States: IDLE, WAIT, DONE.
- op_req_ready = ~ip_flush & (IDLE | (DONE & ip_resp_ready)). A request is accepted on an edge where ip_req_valid & op_req_ready.
- On accept:
  - Register rs1, rs2, funct3 into op_ext_*. Register rd.
  - Classify the request combinationally from the ip_* inputs:
    - div0: funct3[2] & (rs2==0)
    - ovf: funct3[2] & ~funct3[0] & rs1==32'h8000_0000 & rs2==32'hFFFF_FFFF
  - If div0 or ovf, load the fixed result and go to DONE:
    - div0 with funct3[1]=0 (DIV/DIVU): 32'hFFFF_FFFF
    - div0 with funct3[1]=1 (REM/REMU): rs1
    - ovf DIV: 32'h8000_0000
    - ovf REM: 0
  - Otherwise load a 6-bit counter with (funct3[2] ? DIV_LAT : MUL_LAT) - 1 and go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture ip_ext_result into the result register and go to DONE.
- DONE:
  - op_resp_valid=1.
  - On ip_resp_ready without a new accept, go to IDLE.
  - On ip_resp_ready with a same-cycle accept, process the new request as from IDLE (back-to-back).
  - Without ip_resp_ready, hold result and rd stable.
- op_ext_* change only on accept, so they are stable through WAIT and DONE.
- ip_flush (any state, highest priority after reset):
  - Next state IDLE; op_resp_valid deasserts next cycle.
  - No request is accepted in that cycle.
  - A result being handed over in DONE with ip_resp_ready in the flush cycle counts as consumed; flush does not retract it.
- Arithmetic: the controller performs no arithmetic beyond the counter and the two equality compares. All results are 32-bit, passed unmodified.

## Timing
- Reset values: state IDLE; op_req_ready=1 (when ip_flush=0); op_resp_valid=0; op_busy=0; op_ext_rs1/rs2=0; op_ext_funct_3=0; op_resp_result=0; op_resp_rd=0; counter=0.
- Normal latency: accept edge E0 → op_resp_valid high after edge E0+LAT, where LAT is MUL_LAT or DIV_LAT. The datapath sees stable operands for exactly LAT cycles before capture.
- Special-case latency: op_resp_valid high after edge E0+1.
- Throughput with ip_resp_ready held high: one operation per LAT+1 cycles (DONE overlaps with the next accept).
- Reset asserted mid-operation: the next edge returns all registers to reset values and any in-flight result is discarded. Reset overrides flush and accept.
- LAT=1: WAIT lasts one cycle (counter loads 0).

## Test plan
- MUL: rs1=7, rs2=-3 (32'hFFFF_FFFD), funct3=000, rd=5, MUL_LAT=2, model returns 32'hFFFF_FFEB → op_resp_valid rises 2 cycles after accept, result 32'hFFFF_FFEB, rd=5; op_ext_* stable throughout.
- DIV by zero: rs1=100, rs2=0, funct3=100 → valid after 1 cycle, result 32'hFFFF_FFFF. Same with funct3=111 → result 100. ip_ext_result ignored in both.
- Overflow: rs1=32'h8000_0000, rs2=32'hFFFF_FFFF, funct3=100 → result 32'h8000_0000. funct3=110 → result 0. funct3=101 (DIVU) → normal WAIT of DIV_LAT cycles.
- Backpressure: hold ip_resp_ready=0 for 10 cycles in DONE → op_resp_valid, result, rd stable and op_req_ready=0. Then raise ip_resp_ready with a new request pending → both handshakes complete on the same edge.
- Flush: assert ip_flush in the second WAIT cycle with DIV_LAT=4 → IDLE next cycle, no op_resp_valid ever for that request. A request held valid during the flush cycle is accepted only on the following edge.
- Reset in DONE with ip_resp_ready=0 → all outputs at reset values after the next edge; a subsequent MULHU (rs1=rs2=32'hFFFF_FFFF, model result 32'hFFFF_FFFE) completes normally.
